// File: rtl/processor_controller.sv
// processor_controller: multi-cycle control unit for the small processor datapath.
//
// Sequences IDLE -> FETCH -> DECODE -> EXECUTE for every instruction and parks in
// HALT after a halt opcode. The instruction and the ALU zero flag are latched at
// the DECODE->EXECUTE edge; all outputs are a Moore decode of the state and that
// latched copy, so none of them follows an input combinationally.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   instruction  in   IR contents, sampled at the DECODE->EXECUTE edge
//   zero_flag    in   ALU zero flag, sampled at the DECODE->EXECUTE edge (jz)
//   increment    out  PC increment strobe (FETCH)
//   ir_en        out  IR load enable (FETCH)
//   alu_in       out  ALU operation (EXECUTE of add/sub/mul)
//   a_mux/b_mux  out  source register selects
//   c_mux        out  destination select; non-zero acts as the write strobe
//   imm_en       out  write imm_value into register c_mux (ldi)
//   imm_value    out  immediate data
//   pc_load      out  load PC with pc_target (jmp, taken jz)
//   pc_target    out  jump target
//   halted       out  controller stopped
//   retired      out  completed-instruction count, wraps at 2^CNT_W
module processor_controller #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               zero_flag,
    output logic               increment,
    output logic               ir_en,
    output logic [OP_W-1:0]    alu_in,
    output logic [SEL_W-1:0]   a_mux,
    output logic [SEL_W-1:0]   b_mux,
    output logic [SEL_W-1:0]   c_mux,
    output logic               imm_en,
    output logic [ADDR_W-1:0]  imm_value,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpMul  = 3'b010,
        OpLdi  = 3'b011,
        OpJmp  = 3'b100,
        OpJz   = 3'b101,
        OpNop  = 3'b110,
        OpHalt = 3'b111
    } op_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               taken_q, taken_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // Field extraction from the latched instruction.
    logic [OP_W-1:0]   op_field;
    logic [SEL_W-1:0]  a_field;
    logic [SEL_W-1:0]  b_field;
    logic [SEL_W-1:0]  c_field;
    logic [ADDR_W-1:0] imm_field;
    logic              op_valid;
    op_e               op;

    assign op_field  = ir_q[INSTR_W-1 -: OP_W];
    assign a_field   = ir_q[INSTR_W-OP_W-1 -: SEL_W];
    assign b_field   = ir_q[INSTR_W-OP_W-SEL_W-1 -: SEL_W];
    assign c_field   = ir_q[INSTR_W-OP_W-2*SEL_W-1 -: SEL_W];
    assign imm_field = ir_q[ADDR_W-1:0];

    // Wide opcodes with any upper bit set fall back to nop.
    assign op_valid = ((op_field >> 3) == '0);
    assign op       = op_valid ? op_e'(op_field[2:0]) : OpNop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            taken_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            taken_q   <= taken_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        taken_d   = taken_q;
        retired_d = retired_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d    = instruction;
                taken_d = zero_flag;
                state_d = StExecute;
            end
            StExecute: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = (op == OpHalt) ? StHalt : StFetch;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        increment = 1'b0;
        ir_en     = 1'b0;
        alu_in    = '0;
        a_mux     = '0;
        b_mux     = '0;
        c_mux     = '0;
        imm_en    = 1'b0;
        imm_value = '0;
        pc_load   = 1'b0;
        pc_target = '0;
        halted    = 1'b0;
        unique case (state_q)
            StFetch: begin
                increment = 1'b1;
                ir_en     = 1'b1;
            end
            StExecute: begin
                unique case (op)
                    OpAdd, OpSub, OpMul: begin
                        alu_in = op_field;
                        a_mux  = a_field;
                        b_mux  = b_field;
                        c_mux  = c_field;
                    end
                    OpLdi: begin
                        imm_en    = 1'b1;
                        c_mux     = c_field;
                        imm_value = imm_field;
                    end
                    OpJmp: begin
                        pc_load   = 1'b1;
                        pc_target = imm_field;
                    end
                    OpJz: begin
                        // Condition was frozen at the DECODE->EXECUTE edge.
                        pc_load   = taken_q;
                        pc_target = imm_field;
                    end
                    default: ;
                endcase
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_processor_controller.sv
// Self-checking bench for processor_controller. Two instances run in lockstep:
// u0 with default parameters and u1 with INSTR_W=24, SEL_W=3, CNT_W=4 (wide
// fields, short wrapping counter). An instruction-level model predicts every
// output on every falling edge; directed literal checks pin the model.
module tb_processor_controller;

    localparam int P_IDLE = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC = 2;
    localparam int P_EXE = 3;
    localparam int P_HALT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_a = '0;
    logic [23:0] instr_b = '0;
    logic        zero_flag = 1'b0;

    logic        u0_inc, u0_ir, u0_ie, u0_pl, u0_h;
    logic [2:0]  u0_alu;
    logic [1:0]  u0_a, u0_b, u0_c;
    logic [7:0]  u0_imm, u0_pt;
    logic [15:0] u0_ret;

    logic        u1_inc, u1_ir, u1_ie, u1_pl, u1_h;
    logic [2:0]  u1_alu;
    logic [2:0]  u1_a, u1_b, u1_c;
    logic [7:0]  u1_imm, u1_pt;
    logic [3:0]  u1_ret;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    processor_controller u0 (
        .clk(clk), .rst(rst), .instruction(instr_a), .zero_flag(zero_flag),
        .increment(u0_inc), .ir_en(u0_ir), .alu_in(u0_alu), .a_mux(u0_a),
        .b_mux(u0_b), .c_mux(u0_c), .imm_en(u0_ie), .imm_value(u0_imm),
        .pc_load(u0_pl), .pc_target(u0_pt), .halted(u0_h), .retired(u0_ret)
    );

    processor_controller #(
        .INSTR_W(24), .OP_W(3), .SEL_W(3), .ADDR_W(8), .CNT_W(4)
    ) u1 (
        .clk(clk), .rst(rst), .instruction(instr_b), .zero_flag(zero_flag),
        .increment(u1_inc), .ir_en(u1_ir), .alu_in(u1_alu), .a_mux(u1_a),
        .b_mux(u1_b), .c_mux(u1_c), .imm_en(u1_ie), .imm_value(u1_imm),
        .pc_load(u1_pl), .pc_target(u1_pt), .halted(u1_h), .retired(u1_ret)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int inc; int ir; int alu; int a; int b; int c;
        int ie; int imm; int pl; int pt; int h;
    } exp_t;

    int m_phase[2];
    int m_ir[2];
    int m_taken[2];
    int m_ret[2];

    function automatic exp_t model_out(input int phase, input int ir, input int taken,
                                       input int iw, input int sw);
        exp_t e;
        int   op, fa, fb, fc, imm, smask;
        e     = '0;
        smask = (1 << sw) - 1;
        op    = (ir >> (iw - 3)) & 7;
        fa    = (ir >> (iw - 3 - sw)) & smask;
        fb    = (ir >> (iw - 3 - 2 * sw)) & smask;
        fc    = (ir >> (iw - 3 - 3 * sw)) & smask;
        imm   = ir & 255;
        if (phase == P_FETCH) begin
            e.inc = 1; e.ir = 1;
        end else if (phase == P_HALT) begin
            e.h = 1;
        end else if (phase == P_EXE) begin
            case (op)
                0, 1, 2: begin e.alu = op; e.a = fa; e.b = fb; e.c = fc; end
                3:       begin e.ie = 1; e.c = fc; e.imm = imm; end
                4:       begin e.pl = 1; e.pt = imm; end
                5:       begin e.pl = taken; e.pt = imm; end
                default: ;
            endcase
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= P_IDLE; m_ir[i] <= 0; m_taken[i] <= 0; m_ret[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    P_IDLE:  m_phase[i] <= P_FETCH;
                    P_FETCH: m_phase[i] <= P_DEC;
                    P_DEC: begin
                        m_ir[i]    <= (i == 0) ? int'(instr_a) : int'(instr_b);
                        m_taken[i] <= int'(zero_flag);
                        m_phase[i] <= P_EXE;
                    end
                    P_EXE: begin
                        m_ret[i]   <= (m_ret[i] + 1) % ((i == 0) ? 65536 : 16);
                        m_phase[i] <= (((m_ir[i] >> ((i == 0) ? 13 : 21)) & 7) == 7)
                                      ? P_HALT : P_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input int inc, input int ir, input int alu,
                            input int a, input int b, input int c, input int ie,
                            input int imm, input int pl, input int pt, input int h,
                            input int ret);
        exp_t  e;
        string p;
        e = model_out(m_phase[i], m_ir[i], m_taken[i], (i == 0) ? 16 : 24, (i == 0) ? 2 : 3);
        p = $sformatf("u%0d.", i);
        chk({p, "increment"}, inc, e.inc);
        chk({p, "ir_en"}, ir, e.ir);
        chk({p, "alu_in"}, alu, e.alu);
        chk({p, "a_mux"}, a, e.a);
        chk({p, "b_mux"}, b, e.b);
        chk({p, "c_mux"}, c, e.c);
        chk({p, "imm_en"}, ie, e.ie);
        chk({p, "imm_value"}, imm, e.imm);
        chk({p, "pc_load"}, pl, e.pl);
        chk({p, "pc_target"}, pt, e.pt);
        chk({p, "halted"}, h, e.h);
        chk({p, "retired"}, ret, m_ret[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_inst(0, u0_inc, u0_ir, u0_alu, u0_a, u0_b, u0_c, u0_ie, u0_imm,
                     u0_pl, u0_pt, u0_h, u0_ret);
            cmp_inst(1, u1_inc, u1_ir, u1_alu, u1_a, u1_b, u1_c, u1_ie, u1_imm,
                     u1_pl, u1_pt, u1_h, u1_ret);
        end
    end

    // ---------------- stimulus ----------------
    // Leaves the bench 2 time units into a FETCH cycle (bounded wait).
    task automatic sync_fetch();
        int guard = 0;
        while (m_phase[0] != P_FETCH && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk("sync_fetch", m_phase[0], P_FETCH);
    endtask

    // Present an instruction for one FETCH/DECODE; returns 2 units into EXECUTE.
    task automatic issue(input logic [15:0] ia, input logic [23:0] ib, input logic zf);
        sync_fetch();
        instr_a   = ia;
        instr_b   = ib;
        zero_flag = zf;
        @(posedge clk); #2;
        @(posedge clk); #2;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst.increment", u0_inc, 0);
        chk("rst.ir_en", u0_ir, 0);
        chk("rst.halted", u0_h, 0);
        chk("rst.retired", u0_ret, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // add a=1 b=2 c=3 (u1: a=5 b=6 c=7); cycle 1 is IDLE, cycle 2 FETCH.
        instr_a = {3'b000, 2'd1, 2'd2, 2'd3, 7'd0};
        instr_b = {3'b000, 3'd5, 3'd6, 3'd7, 12'd0};
        #4;
        chk("c1.increment", u0_inc, 0);
        #10;
        chk("c2.increment", u0_inc, 1);
        chk("c2.ir_en", u0_ir, 1);
        #10;
        chk("c3.increment", u0_inc, 0);
        #10;
        chk("c4.alu_in", u0_alu, 0);
        chk("c4.a_mux", u0_a, 1);
        chk("c4.b_mux", u0_b, 2);
        chk("c4.c_mux", u0_c, 3);
        chk("c4.u1.a_mux", u1_a, 5);
        chk("c4.u1.c_mux", u1_c, 7);
        #10;
        chk("c5.retired", u0_ret, 1);

        // ldi c=2 imm=0x5A
        issue(16'h615A, {3'b011, 3'd0, 3'd0, 3'd7, 12'h0A5}, 1'b0);
        chk("ldi.imm_en", u0_ie, 1);
        chk("ldi.c_mux", u0_c, 2);
        chk("ldi.imm_value", u0_imm, 8'h5A);
        chk("ldi.alu_in", u0_alu, 0);
        chk("ldi.a_mux", u0_a, 0);
        chk("ldi.u1.c_mux", u1_c, 7);
        chk("ldi.u1.imm_value", u1_imm, 8'hA5);

        issue({3'b001, 2'd3, 2'd1, 2'd2, 7'd0}, {3'b001, 3'd1, 3'd2, 3'd3, 12'd0}, 1'b0);
        chk("sub.alu_in", u0_alu, 1);
        chk("sub.a_mux", u0_a, 3);
        issue({3'b010, 2'd2, 2'd2, 2'd1, 7'd0}, {3'b010, 3'd4, 3'd4, 3'd2, 12'd0}, 1'b0);
        chk("mul.alu_in", u0_alu, 2);

        issue({3'b100, 13'h0033}, {3'b100, 21'h000033}, 1'b0);
        chk("jmp.pc_load", u0_pl, 1);
        chk("jmp.pc_target", u0_pt, 8'h33);
        chk("jmp.increment", u0_inc, 0);

        // jz taken; flag flipped during EXECUTE must not matter.
        issue({3'b101, 13'h0040}, {3'b101, 21'h000040}, 1'b1);
        chk("jz1.pc_load", u0_pl, 1);
        chk("jz1.pc_target", u0_pt, 8'h40);
        zero_flag = 1'b0;
        #1 chk("jz1.hold", u0_pl, 1);
        issue({3'b101, 13'h0040}, {3'b101, 21'h000040}, 1'b0);
        chk("jz0.pc_load", u0_pl, 0);
        zero_flag = 1'b1;
        #1 chk("jz0.hold", u0_pl, 0);

        // nop with all field bits set: no strobe may escape.
        issue({3'b110, 13'h1FFF}, {3'b110, 21'h1FFFFF}, 1'b0);
        chk("nop.c_mux", u0_c, 0);
        chk("nop.pc_load", u0_pl, 0);
        @(posedge clk); #2;
        chk("ret8", u0_ret, 8);

        // reset mid-DECODE of a mul
        sync_fetch();
        instr_a = {3'b010, 2'd1, 2'd1, 2'd3, 7'd0};
        instr_b = {3'b010, 3'd1, 3'd1, 3'd3, 12'd0};
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rstmid.alu_in", u0_alu, 0);
        chk("rstmid.c_mux", u0_c, 0);
        chk("rstmid.increment", u0_inc, 0);
        chk("rstmid.retired", u0_ret, 0);
        chk("rstmid.u1.retired", u1_ret, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // 15 nops then halt: u1 (CNT_W=4) wraps to 0 on the halt edge.
        for (int k = 0; k < 15; k++) issue({3'b110, 13'h0}, {3'b110, 21'h0}, 1'b0);
        issue({3'b111, 13'h0}, {3'b111, 21'h0}, 1'b0);
        chk("halt.exec.halted", u0_h, 0);
        @(posedge clk); #2;
        chk("halt.halted", u0_h, 1);
        chk("halt.retired", u0_ret, 16);
        chk("halt.u1.halted", u1_h, 1);
        chk("halt.u1.retired", u1_ret, 0);
        repeat (20) @(posedge clk);
        #2;
        chk("halt20.increment", u0_inc, 0);
        chk("halt20.retired", u0_ret, 16);
        chk("halt20.halted", u0_h, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
